// File: rtl/store_narrow_unit.sv
// Store narrowing unit: turns a MEM-stage store into an aligned, byte-enabled
// req/ack write to data memory, and reports misaligned or timed-out stores.
module store_narrow_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        st_done,
    output logic        st_err,
    output logic [31:0] bad_addr
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    // Last REQ cycle that may still see an ack; the abort fires when it passes silently.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        memReq_q, memReq_d;
    logic [31:0] memAddr_q, memAddr_d;
    logic [31:0] memWdata_q, memWdata_d;
    logic [3:0]  memBe_q, memBe_d;
    logic [31:0] stAddr_q, stAddr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] badAddr_q, badAddr_d;

    logic        aligned;
    logic [31:0] narrowWdata;
    logic [3:0]  narrowBe;

    // Decode the incoming store: alignment legality, replicated data and lane enables.
    always_comb begin
        aligned     = 1'b0;
        narrowWdata = st_data;
        narrowBe    = 4'b0000;
        case (st_op)
            2'b00: begin
                aligned     = (st_addr[1:0] == 2'b00);
                narrowWdata = st_data;
                narrowBe    = 4'b1111;
            end
            2'b01: begin
                aligned     = (st_addr[0] == 1'b0);
                narrowWdata = {2{st_data[15:0]}};
                narrowBe    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                aligned     = 1'b1;
                narrowWdata = {4{st_data[7:0]}};
                narrowBe    = 4'b0001 << st_addr[1:0];
            end
            default: begin
                aligned     = 1'b0;
                narrowWdata = st_data;
                narrowBe    = 4'b0000;
            end
        endcase
    end

    // Next-state and registered-output logic for the IDLE/REQ handshake.
    always_comb begin
        state_d    = state_q;
        memReq_d   = memReq_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memBe_d    = memBe_q;
        stAddr_d   = stAddr_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        badAddr_d  = badAddr_q;
        case (state_q)
            IDLE: begin
                if (st_valid) begin
                    if (!aligned) begin
                        err_d     = 1'b1;
                        badAddr_d = st_addr;
                    end else begin
                        state_d    = REQ;
                        memReq_d   = 1'b1;
                        memAddr_d  = {st_addr[31:2], 2'b00};
                        memWdata_d = narrowWdata;
                        memBe_d    = narrowBe;
                        stAddr_d   = st_addr;
                        cnt_d      = 8'd0;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    memReq_d = 1'b0;
                    memBe_d  = 4'b0000;
                    done_d   = 1'b1;
                    cnt_d    = 8'd0;
                end else if (cnt_q == CntLast) begin
                    state_d   = IDLE;
                    memReq_d  = 1'b0;
                    memBe_d   = 4'b0000;
                    err_d     = 1'b1;
                    badAddr_d = stAddr_q;
                    cnt_d     = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                memReq_d = 1'b0;
                memBe_d  = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight store silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            memReq_q   <= 1'b0;
            memAddr_q  <= 32'd0;
            memWdata_q <= 32'd0;
            memBe_q    <= 4'b0000;
            stAddr_q   <= 32'd0;
            cnt_q      <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            badAddr_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            memReq_q   <= memReq_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memBe_q    <= memBe_d;
            stAddr_q   <= stAddr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            badAddr_q  <= badAddr_d;
        end
    end

    assign st_ready  = (state_q == IDLE);
    assign stall     = (state_q != IDLE);
    assign mem_req   = memReq_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign mem_be    = memBe_q;
    assign st_done   = done_q;
    assign st_err    = err_q;
    assign bad_addr  = badAddr_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: directed vector table, randomized
// stores against a reference model, plus reset and back-to-back sequences.
module tb_store_narrow_unit;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        st_done;
    logic        st_err;
    logic [31:0] bad_addr;

    int checks = 0;
    int errors = 0;

    // kind: 0 = committed on ack, 1 = rejected at accept, 2 = aborted by timeout
    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          ackDelay;
        int          kind;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [3:0]  expBe;
    } vec_t;

    vec_t vecs[10];

    store_narrow_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .st_done(st_done), .st_err(st_err),
        .bad_addr(bad_addr)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expectations derived from the store rules with plain arithmetic.
    function automatic vec_t modelStore(input logic [1:0] op, input logic [31:0] addr,
                                        input logic [31:0] data, input int ackDelay);
        vec_t v;
        int lane;
        lane       = int'(addr % 4);
        v.op       = op;
        v.addr     = addr;
        v.data     = data;
        v.ackDelay = ackDelay;
        v.expAddr  = addr - (addr % 4);
        v.expWdata = data;
        v.expBe    = 4'd15;
        if (op == 2'd3 || (op == 2'd0 && lane != 0) || (op == 2'd1 && lane % 2 != 0))
            v.kind = 1;
        else if (ackDelay < TIMEOUT)
            v.kind = 0;
        else
            v.kind = 2;
        if (op == 2'd1) begin
            v.expWdata = (data % 32'h10000) * 32'h00010001;
            v.expBe    = 4'(3 << lane);
        end else if (op == 2'd2) begin
            v.expWdata = (data % 32'h100) * 32'h01010101;
            v.expBe    = 4'(1 << lane);
        end
        return v;
    endfunction

    // Runs one store from IDLE (called at a negedge) and checks every cycle of it.
    task automatic applyStimulus(input vec_t v);
        int exitCycle;
        bit finished;
        exitCycle = (v.ackDelay < TIMEOUT) ? v.ackDelay : TIMEOUT - 1;
        checkOutput("ready_before", st_ready, 1);
        st_valid = 1'b1;
        st_op    = v.op;
        st_addr  = v.addr;
        st_data  = v.data;
        @(posedge clk);
        @(negedge clk);
        st_valid = 1'b0;
        if (v.kind == 1) begin
            checkOutput("err_reject", st_err, 1);
            checkOutput("bad_addr_reject", bad_addr, v.addr);
            checkOutput("req_reject", mem_req, 0);
            checkOutput("done_reject", st_done, 0);
            checkOutput("ready_reject", st_ready, 1);
            @(negedge clk);
            checkOutput("err_pulse", st_err, 0);
            checkOutput("req_after_reject", mem_req, 0);
            return;
        end
        checkOutput("req_start", mem_req, 1);
        checkOutput("mem_addr", mem_addr, v.expAddr);
        checkOutput("mem_wdata", mem_wdata, v.expWdata);
        checkOutput("mem_be", mem_be, v.expBe);
        checkOutput("stall_req", stall, 1);
        checkOutput("err_start", st_err, 0);
        finished = 1'b0;
        for (int k = 0; k < TIMEOUT && !finished; k++) begin
            if (k == v.ackDelay) mem_ack = 1'b1;
            checkOutput("req_hold", mem_req, 1);
            checkOutput("addr_hold", mem_addr, v.expAddr);
            checkOutput("be_hold", mem_be, v.expBe);
            @(posedge clk);
            @(negedge clk);
            mem_ack = 1'b0;
            if (k == exitCycle) begin
                finished = 1'b1;
                checkOutput("done_exit", st_done, (v.kind == 0) ? 1 : 0);
                checkOutput("err_exit", st_err, (v.kind == 2) ? 1 : 0);
                checkOutput("req_exit", mem_req, 0);
                checkOutput("be_exit", mem_be, 0);
                checkOutput("ready_exit", st_ready, 1);
                if (v.kind == 2) checkOutput("bad_addr_timeout", bad_addr, v.addr);
            end else begin
                checkOutput("done_early", st_done, 0);
                checkOutput("err_early", st_err, 0);
            end
        end
        checkOutput("exit_reached", finished, 1);
        @(negedge clk);
        checkOutput("done_pulse", st_done, 0);
        checkOutput("err_pulse2", st_err, 0);
    endtask

    initial begin
        st_valid = 1'b0;
        st_op    = 2'd0;
        st_addr  = 32'd0;
        st_data  = 32'd0;
        mem_ack  = 1'b0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_ready", st_ready, 1);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        checkOutput("rst_be", mem_be, 0);
        checkOutput("rst_done", st_done, 0);
        checkOutput("rst_err", st_err, 0);
        checkOutput("rst_bad", bad_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{2'd0, 32'h100, 32'hDEADBEEF, 0,  0, 32'h100, 32'hDEADBEEF, 4'b1111};
        vecs[1] = '{2'd2, 32'h203, 32'h12345678, 2,  0, 32'h200, 32'h78787878, 4'b1000};
        vecs[2] = '{2'd1, 32'h202, 32'hCAFEBABE, 1,  0, 32'h200, 32'hBABEBABE, 4'b1100};
        vecs[3] = '{2'd1, 32'h200, 32'h0000A5C3, 0,  0, 32'h200, 32'hA5C3A5C3, 4'b0011};
        vecs[4] = '{2'd2, 32'h201, 32'h000000E1, 3,  0, 32'h200, 32'hE1E1E1E1, 4'b0010};
        vecs[5] = '{2'd0, 32'h102, 32'h11111111, 0,  1, 32'h0,   32'h0,        4'b0000};
        vecs[6] = '{2'd1, 32'h101, 32'h22222222, 0,  1, 32'h0,   32'h0,        4'b0000};
        vecs[7] = '{2'd3, 32'h300, 32'h33333333, 0,  1, 32'h0,   32'h0,        4'b0000};
        vecs[8] = '{2'd0, 32'h400, 32'h44444444, 99, 2, 32'h400, 32'h44444444, 4'b1111};
        vecs[9] = '{2'd0, 32'h500, 32'h55555555, 15, 0, 32'h500, 32'h55555555, 4'b1111};

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
        checkOutput("bad_addr_held", bad_addr, 32'h400);

        // Randomized stores; an idle cycle with a stray ack precedes each one.
        for (int i = 0; i < 40; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            mem_ack = 1'b0;
            checkOutput("idle_ack_ignored", st_done, 0);
            applyStimulus(modelStore(2'($urandom_range(0, 3)), $urandom, $urandom,
                                     int'($urandom_range(0, 19))));
        end

        // Reset while a store waits for ack.
        st_valid = 1'b1; st_op = 2'd0; st_addr = 32'h600; st_data = 32'h66666666;
        @(posedge clk);
        @(negedge clk);
        st_valid = 1'b0;
        checkOutput("rstmid_req_before", mem_req, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_req", mem_req, 0);
        checkOutput("rstmid_be", mem_be, 0);
        checkOutput("rstmid_addr", mem_addr, 0);
        checkOutput("rstmid_wdata", mem_wdata, 0);
        checkOutput("rstmid_bad", bad_addr, 0);
        checkOutput("rstmid_ready", st_ready, 1);
        @(negedge clk);
        mem_ack = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("rstmid_no_done", st_done, 0);
        checkOutput("rstmid_no_err", st_err, 0);
        checkOutput("rstmid_ready_after", st_ready, 1);
        @(negedge clk);

        // Back-to-back byte stores with st_valid held high.
        st_valid = 1'b1; st_op = 2'd2; st_addr = 32'h700; st_data = 32'h000000AB;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_stall1", stall, 1);
        checkOutput("b2b_be1", mem_be, 4'b0001);
        checkOutput("b2b_wdata1", mem_wdata, 32'hABABABAB);
        st_addr = 32'h703; st_data = 32'h000000CD; mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_done1", st_done, 1);
        checkOutput("b2b_ready", st_ready, 1);
        @(posedge clk);
        @(negedge clk);
        st_valid = 1'b0;
        checkOutput("b2b_req2", mem_req, 1);
        checkOutput("b2b_stall2", stall, 1);
        checkOutput("b2b_be2", mem_be, 4'b1000);
        checkOutput("b2b_wdata2", mem_wdata, 32'hCDCDCDCD);
        checkOutput("b2b_done_gap", st_done, 0);
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("b2b_done2", st_done, 1);
        checkOutput("b2b_err2", st_err, 0);
        checkOutput("b2b_req_off", mem_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
